ov7670_dvp_emulator: RTL
========================

// Module: ov7670_dvp_emulator
// PURPOSE
//   Transmit side of the OV7670 DVP camera bus: drives cam_vsync/href/p_data as the sensor would, RGB565 two bytes per pixel, high byte first.
//   Feeds the camera capture FSM (vsync/href/byte-pair assembly into the 17-bit cam FIFO) in place of a real sensor, for board bring-up and sim.
//   Pixel content comes from a selectable deterministic pattern, so the frame reaching the LCD path is predictable.
// PARAMETERS
//   FRAME_WIDTH     640     active pixels per line (2*FRAME_WIDTH bytes per line)
//   FRAME_HEIGHT    480     active lines per frame
//   H_BLANK         144     href-low clocks after each line's active bytes (>=1)
//   VSYNC_LINES     3       line periods with cam_vsync high at frame start (>=1)
//   V_BACK_PORCH    17      line periods after vsync, before first active line (>=0)
//   V_FRONT_PORCH   10      line periods after last active line (>=0)
//   SOLID_COLOR     16'hF800  RGB565 value for pattern 2
// PORTS
//   clk          in   1   byte clock; one p_data byte per cycle
//   reset_p      in   1   synchronous active-high reset
//   enable       in   1   run request; sampled only in IDLE and at frame end
//   pattern_sel  in   2   0 colour bars, 1 coordinate, 2 solid, 3 checker; latched at frame start
//   cam_vsync    out  1   high = vertical sync (frame boundary)
//   href         out  1   high while active bytes of a line are on p_data
//   p_data       out  8   pixel byte; 8'h00 whenever href low
//   frame_start  out  1   one-cycle pulse on the first cycle of VSYNC
//   frame_count  out  16  completed frames, wraps 16'hFFFF -> 0
// BEHAVIOUR
//   - All outputs registered. Reset value: cam_vsync=1, href=0, p_data=0, frame_start=0, frame_count=0, state=IDLE, counters 0.
//   - Line period L = 2*FRAME_WIDTH + H_BLANK clocks; h_cnt counts 0..L-1, wraps and increments v_cnt.
//   - States: IDLE -> VSYNC (VSYNC_LINES lines) -> BACK_PORCH (V_BACK_PORCH lines) -> ACTIVE (FRAME_HEIGHT lines) -> FRONT_PORCH (V_FRONT_PORCH lines) -> VSYNC if enable else IDLE.
//     Zero-length porch states are skipped in the same transition.
//   - IDLE: cam_vsync=1, href=0; leaves to VSYNC on the cycle after enable=1 is sampled.
//   - VSYNC: cam_vsync=1 for VSYNC_LINES*L clocks; frame_start pulses on its first cycle; pattern_sel latched then.
//   - BACK_PORCH, FRONT_PORCH: cam_vsync=0, href=0.
//   - ACTIVE line: href=1 for h_cnt 0..2*FRAME_WIDTH-1, then 0 for H_BLANK clocks. Pixel x=h_cnt>>1, y=active line index.
//     Even h_cnt emits pixel[15:8], odd h_cnt emits pixel[7:0]; href never drops mid-pixel.
//   - Patterns (RGB565, x,y zero-based):
//     0: 8 bars of width FRAME_WIDTH/8 (last bar absorbs remainder): FFFF,FFE0,07FF,07E0,F81F,F800,001F,0000.
//     1: pixel = {y[6:0], x[8:0]}.
//     2: pixel = SOLID_COLOR.
//     3: pixel = (x[3]^y[3]^frame_count[0]) ? 16'hFFFF : 16'h0000.
//   - Bar index computed with a running column counter, no divider.
//   - frame_count increments on the last cycle of FRONT_PORCH (last ACTIVE cycle if V_FRONT_PORCH=0).
//   - enable dropped mid-frame: current frame completes in full, then IDLE; never a truncated frame.
//   - reset_p mid-frame: all outputs return to reset values next cycle; href/vsync may cut mid-line (reset only).
//   - pattern_sel changes mid-frame: no effect until next frame_start.
//   - Exactly 2*FRAME_WIDTH href-high clocks per active line, exactly FRAME_HEIGHT href pulses per frame.
// TESTING
//   Use FRAME_WIDTH=8, FRAME_HEIGHT=2, H_BLANK=4, VSYNC_LINES=1, V_BACK_PORCH=1, V_FRONT_PORCH=1 (L=20) unless noted.
//   1 Reset, enable=0 for 50 clk -> cam_vsync=1, href=0, p_data=0, frame_count=0 throughout.
//   2 enable=1, pattern 1 -> frame_start once; vsync high 20 clk; 20 clk blank; line0 bytes 00,00,00,01,..,00,07; line1 02,00,02,01,..,02,07.
//   3 Same run -> each line: href high 16 clk, low 4 clk; frame_count=1 after 100 clk frame; next frame_start at clk 100.
//   4 Pattern 0 -> pixel pairs FFFF,FFE0,07FF,07E0,F81F,F800,001F,0000 per line, high byte first.
//   5 Drop enable during ACTIVE line0 -> frame finishes (2 full lines, front porch), frame_count=1, then IDLE with vsync=1.
//   6 Assert reset_p during line1 -> next cycle vsync=1, href=0, p_data=0, frame_count=0; re-enable restarts from VSYNC.
//   7 Capture FSM + cam FIFO bench, 640x480 pattern 3 -> 307200 pixel words per frame match checker model, frame marker first.

Source files
------------

// File: rtl/ov7670_dvp_emulator.sv
// OV7670-style DVP transmitter: drives cam_vsync/href/p_data with RGB565 pixels (high byte first)
// taken from a selectable deterministic test pattern, so a capture path can be exercised without a sensor.
module ov7670_dvp_emulator #(
    parameter int          FRAME_WIDTH   = 640,
    parameter int          FRAME_HEIGHT  = 480,
    parameter int          H_BLANK       = 144,
    parameter int          VSYNC_LINES   = 3,
    parameter int          V_BACK_PORCH  = 17,
    parameter int          V_FRONT_PORCH = 10,
    parameter logic [15:0] SOLID_COLOR   = 16'hF800
) (
    input  logic        clk,
    input  logic        reset_p,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    output logic        cam_vsync,
    output logic        href,
    output logic [7:0]  p_data,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int          LINE_LEN     = 2 * FRAME_WIDTH + H_BLANK;
    localparam int          BAR_W        = (FRAME_WIDTH / 8 > 0) ? FRAME_WIDTH / 8 : 1;
    localparam logic [15:0] LAST_H       = 16'(LINE_LEN - 1);
    localparam logic [15:0] ACTIVE_BYTES = 16'(2 * FRAME_WIDTH);
    localparam logic [15:0] BAR_LAST     = 16'(BAR_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_BACK   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_FRONT  = 3'd4
    } state_t;

    state_t      state_r, state_s;
    logic [15:0] h_cnt_r, h_cnt_s;
    logic [15:0] v_cnt_r, v_cnt_s;
    logic [15:0] bar_cnt_r, bar_cnt_s;
    logic [2:0]  bar_idx_r, bar_idx_s;
    logic [1:0]  pat_r, pat_s;
    logic        frame_end_s;
    logic        fs_s;
    logic [8:0]  x_s;
    logic [6:0]  y_s;
    logic [15:0] pixel_s;
    logic        vsync_s;
    logic        href_s;
    logic [7:0]  data_s;

    function automatic logic [15:0] lines_of(input state_t st);
        case (st)
            ST_VSYNC:  lines_of = 16'(VSYNC_LINES);
            ST_BACK:   lines_of = 16'(V_BACK_PORCH);
            ST_ACTIVE: lines_of = 16'(FRAME_HEIGHT);
            ST_FRONT:  lines_of = 16'(V_FRONT_PORCH);
            default:   lines_of = 16'd1;
        endcase
    endfunction

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_color = 16'hFFFF;
            3'd1:    bar_color = 16'hFFE0;
            3'd2:    bar_color = 16'h07FF;
            3'd3:    bar_color = 16'h07E0;
            3'd4:    bar_color = 16'hF81F;
            3'd5:    bar_color = 16'hF800;
            3'd6:    bar_color = 16'h001F;
            default: bar_color = 16'h0000;
        endcase
    endfunction

    // Next-state, counter and output-value computation; outputs are registered from these next values
    // so that they line up cycle-for-cycle with the state they describe.
    always_comb begin
        state_s     = state_r;
        h_cnt_s     = h_cnt_r + 16'd1;
        v_cnt_s     = v_cnt_r;
        frame_end_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                h_cnt_s = 16'd0;
                v_cnt_s = 16'd0;
                if (enable) begin
                    state_s = ST_VSYNC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_VSYNC, ST_BACK, ST_ACTIVE, ST_FRONT: begin
                if (h_cnt_r == LAST_H) begin
                    h_cnt_s = 16'd0;
                    if (v_cnt_r == lines_of(state_r) - 16'd1) begin
                        v_cnt_s = 16'd0;
                        case (state_r)
                            ST_VSYNC: state_s = (V_BACK_PORCH > 0) ? ST_BACK : ST_ACTIVE;
                            ST_BACK:  state_s = ST_ACTIVE;
                            ST_ACTIVE: begin
                                if (V_FRONT_PORCH > 0) begin
                                    state_s = ST_FRONT;
                                end else begin
                                    frame_end_s = 1'b1;
                                    state_s     = enable ? ST_VSYNC : ST_IDLE;
                                end
                            end
                            default: begin
                                frame_end_s = 1'b1;
                                state_s     = enable ? ST_VSYNC : ST_IDLE;
                            end
                        endcase
                    end else begin
                        v_cnt_s = v_cnt_r + 16'd1;
                    end
                end else begin
                    h_cnt_s = h_cnt_r + 16'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                h_cnt_s = 16'd0;
                v_cnt_s = 16'd0;
            end
        endcase

        fs_s  = ((state_r == ST_IDLE) || frame_end_s) && (state_s == ST_VSYNC);
        pat_s = fs_s ? pattern_sel : pat_r;

        // Running bar column: advances once per pixel (even byte), last bar soaks up any remainder.
        bar_cnt_s = bar_cnt_r;
        bar_idx_s = bar_idx_r;
        if (h_cnt_s == 16'd0) begin
            bar_cnt_s = 16'd0;
            bar_idx_s = 3'd0;
        end else if (!h_cnt_s[0]) begin
            if ((bar_cnt_r == BAR_LAST) && (bar_idx_r != 3'd7)) begin
                bar_cnt_s = 16'd0;
                bar_idx_s = bar_idx_r + 3'd1;
            end else begin
                bar_cnt_s = bar_cnt_r + 16'd1;
            end
        end else begin
            bar_cnt_s = bar_cnt_r;
        end

        x_s = h_cnt_s[9:1];
        y_s = v_cnt_s[6:0];
        case (pat_s)
            2'd0:    pixel_s = bar_color(bar_idx_s);
            2'd1:    pixel_s = {y_s, x_s};
            2'd2:    pixel_s = SOLID_COLOR;
            default: pixel_s = (x_s[3] ^ y_s[3] ^ frame_count[0]) ? 16'hFFFF : 16'h0000;
        endcase

        vsync_s = (state_s == ST_IDLE) || (state_s == ST_VSYNC);
        href_s  = (state_s == ST_ACTIVE) && (h_cnt_s < ACTIVE_BYTES);
        if (href_s) begin
            data_s = h_cnt_s[0] ? pixel_s[7:0] : pixel_s[15:8];
        end else begin
            data_s = 8'h00;
        end
    end

    // Frame sequencer state, counters and registered bus outputs.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            state_r     <= ST_IDLE;
            h_cnt_r     <= 16'd0;
            v_cnt_r     <= 16'd0;
            bar_cnt_r   <= 16'd0;
            bar_idx_r   <= 3'd0;
            pat_r       <= 2'd0;
            cam_vsync   <= 1'b1;
            href        <= 1'b0;
            p_data      <= 8'h00;
            frame_start <= 1'b0;
            frame_count <= 16'd0;
        end else begin
            state_r     <= state_s;
            h_cnt_r     <= h_cnt_s;
            v_cnt_r     <= v_cnt_s;
            bar_cnt_r   <= bar_cnt_s;
            bar_idx_r   <= bar_idx_s;
            pat_r       <= pat_s;
            cam_vsync   <= vsync_s;
            href        <= href_s;
            p_data      <= data_s;
            frame_start <= fs_s;
            if (frame_end_s) begin
                frame_count <= frame_count + 16'd1;
            end else begin
                frame_count <= frame_count;
            end
        end
    end

endmodule
